dmx_slot_receiver: RTL and testbench

DMX_SLOT_RECEIVER -- requirements
Module: dmx_slot_receiver

---
 rtl/dmx_pkg.sv | 22 ++
 rtl/dmx_slot_receiver_if.sv | 12 +
 rtl/dmx_uart_rx.sv | 107 ++++++++++
 rtl/dmx_slot_receiver.sv | 122 ++++++++++++
 tb/tb_dmx_slot_receiver.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmx_pkg.sv
// Shared types and constants for the DMX512 slot receiver.
// Frame and UART state enums live here so the top and the UART agree.
package dmx_pkg;

    localparam int DMX_MAX_SLOTS = 512;
    localparam logic [7:0] DMX_NULL_START_CODE = 8'h00;

    typedef enum logic [1:0] {
        F_IDLE,
        F_START,
        F_SLOTS
    } frame_state_e;

    typedef enum logic [2:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP1,
        U_STOP2
    } uart_state_e;

endpackage

// File: rtl/dmx_slot_receiver_if.sv
// Slot-buffer write bus of the DMX receiver.
// The receiver drives it through master; the buffer listens through slave.
interface dmx_slot_receiver_if;

    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/dmx_uart_rx.sv
// 8N2 receiver for the DMX line: two-flop sync, mid-bit sampling, stop check.
// byte_valid_o or frame_err_o pulses one cycle after the second stop sample.
module dmx_uart_rx
    import dmx_pkg::*;
#(
    parameter int BIT_CYCLES = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int HALF = (BIT_CYCLES / 2 > 0) ? BIT_CYCLES / 2 : 1;
    localparam logic [15:0] HALF_END = 16'(HALF - 1);
    localparam logic [15:0] BIT_END  = 16'(BIT_CYCLES - 1);

    uart_state_e state_q, state_d;
    logic        s1_q, s2_q, prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bitn_q, bitn_d;
    logic [7:0]  sh_q, sh_d;
    logic        err_q, err_d;
    logic        bv_q, bv_d;
    logic        fe_q, fe_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= U_IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            sh_q    <= '0;
            err_q   <= 1'b0;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            s1_q    <= rx_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            sh_q    <= sh_d;
            err_q   <= err_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bitn_d  = bitn_q;
        sh_d    = sh_q;
        err_d   = err_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        unique case (state_q)
            U_IDLE: begin
                cnt_d = '0;
                if (prev_q && !s2_q) state_d = U_START;
            end
            U_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    bitn_d  = '0;
                    err_d   = 1'b0;
                    state_d = s2_q ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d  = '0;
                    sh_d   = {s2_q, sh_q[7:1]};
                    bitn_d = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) state_d = U_STOP1;
                end
            end
            U_STOP1: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    err_d   = !s2_q;
                    state_d = U_STOP2;
                end
            end
            U_STOP2: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    fe_d    = err_q | !s2_q;
                    bv_d    = !(err_q | !s2_q);
                    state_d = U_IDLE;
                end
            end
            default: state_d = U_IDLE;
        endcase
    end

    assign byte_o       = sh_q;
    assign byte_valid_o = bv_q;
    assign frame_err_o  = fe_q;

endmodule

// File: rtl/dmx_slot_receiver.sv
// DMX512 slot receiver: start code capture and slot-buffer writes per frame.
// Define DMX_RX_START_CODE_FILTER_EN to accept only the null start code.
module dmx_slot_receiver
    import dmx_pkg::*;
#(
    parameter int CLK_FREQ  = 20_000_000,
    parameter int BAUD      = 250_000,
    parameter int MAX_SLOTS = DMX_MAX_SLOTS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 break_valid,
    dmx_slot_receiver_if.master  wr,
    output logic [7:0]           start_code,
    output logic                 frame_done,
    output logic [9:0]           slot_count,
    output logic                 frame_err
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam logic [9:0] MAX_L = 10'(MAX_SLOTS);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       uart_err;

    dmx_uart_rx #(.BIT_CYCLES(BIT_CYCLES)) u_uart (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .byte_o      (rx_byte),
        .byte_valid_o(byte_valid),
        .frame_err_o (uart_err)
    );

    frame_state_e state_q, state_d;
    logic [9:0]   idx_q, idx_d;
    logic [7:0]   sc_q, sc_d;
    logic [9:0]   cnt_q, cnt_d;
    logic         wr_en_q, wr_en_d;
    logic [8:0]   addr_q, addr_d;
    logic [7:0]   data_q, data_d;
    logic         done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= F_IDLE;
            idx_q   <= '0;
            sc_q    <= '0;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sc_q    <= sc_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sc_d    = sc_q;
        cnt_d   = cnt_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        // A break outranks a coincident byte, which is then dropped.
        if (break_valid) begin
            if (state_q == F_SLOTS && idx_q != '0) begin
                done_d = 1'b1;
                cnt_d  = idx_q;
            end
            idx_d   = '0;
            state_d = F_START;
        end else if (uart_err) begin
            if (state_q != F_IDLE) state_d = F_IDLE;
        end else if (byte_valid) begin
            unique case (state_q)
                F_START: begin
                    sc_d    = rx_byte;
                    idx_d   = '0;
`ifdef DMX_RX_START_CODE_FILTER_EN
                    state_d = (rx_byte == DMX_NULL_START_CODE) ? F_SLOTS : F_IDLE;
`else
                    state_d = F_SLOTS;
`endif
                end
                F_SLOTS: begin
                    wr_en_d = 1'b1;
                    addr_d  = idx_q[8:0];
                    data_d  = rx_byte;
                    idx_d   = idx_q + 10'd1;
                    if (idx_q + 10'd1 == MAX_L) begin
                        done_d  = 1'b1;
                        cnt_d   = MAX_L;
                        state_d = F_IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign wr.wr_en   = wr_en_q;
    assign wr.wr_addr = addr_q;
    assign wr.wr_data = data_q;
    assign start_code = sc_q;
    assign frame_done = done_q;
    assign slot_count = cnt_q;
    assign frame_err  = uart_err;

endmodule

// File: tb/tb_dmx_slot_receiver.sv
// Directed bench for dmx_slot_receiver at a fast bit rate (8 clocks per bit).
// Expected values are hand-derived from the frame sequences driven below.
module tb_dmx_slot_receiver;

    localparam int CLK_FREQ = 20_000_000;
    localparam int BAUD     = 2_500_000;
    localparam int BIT      = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       break_valid = 1'b0;
    logic [7:0] start_code;
    logic       frame_done;
    logic [9:0] slot_count;
    logic       frame_err;

    dmx_slot_receiver_if bus ();

    dmx_slot_receiver #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .break_valid(break_valid),
        .wr         (bus),
        .start_code (start_code),
        .frame_done (frame_done),
        .slot_count (slot_count),
        .frame_err  (frame_err)
    );

    always #25 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         wr_total = 0;
    int         fd_total = 0;
    int         fe_total = 0;
    logic [7:0] mem [512];

    always @(negedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
            wr_total <= wr_total + 1;
        end
        if (frame_done) fd_total <= fd_total + 1;
        if (frame_err)  fe_total <= fe_total + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop1);
        @(negedge clk) rx_in = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx_in = stop1;
        repeat (BIT) @(negedge clk);
        rx_in = 1'b1;
        repeat (BIT) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_break();
        @(negedge clk) break_valid = 1'b1;
        @(negedge clk) break_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_with_break(input logic [7:0] b);
        bit found;
        found = 1'b0;
        fork
            send_byte(b, 1'b1);
            begin
                for (int i = 0; i < 12 * BIT && !found; i++) begin
                    @(negedge clk);
                    if (u_dut.byte_valid) begin
                        break_valid = 1'b1;
                        @(negedge clk) break_valid = 1'b0;
                        found = 1'b1;
                    end
                end
            end
        join
        check("coinc_bv_seen", int'(found), 1);
    endtask

    int wr0, fd0, fe0;

    task automatic snap();
        @(negedge clk);
        wr0 = wr_total;
        fd0 = fd_total;
        fe0 = fe_total;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_start_code", int'(start_code), 0);
        check("rst_slot_count", int'(slot_count), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_err", int'(frame_err), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        snap();
        send_byte(8'h33, 1'b1);
        check("idle_discard_wr", wr_total - wr0, 0);
        check("idle_discard_sc", int'(start_code), 0);

        snap();
        pulse_break();
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        pulse_break();
        check("f2_writes", wr_total - wr0, 2);
        check("f2_addr0", int'(mem[0]), 8'h11);
        check("f2_addr1", int'(mem[1]), 8'h22);
        check("f2_done", fd_total - fd0, 1);
        check("f2_count", int'(slot_count), 2);
        check("f2_start_code", int'(start_code), 0);

        snap();
        pulse_break();
        check("break_in_start_no_done", fd_total - fd0, 0);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b1);
        check("full_writes", wr_total - wr0, 512);
        check("full_done", fd_total - fd0, 1);
        check("full_count", int'(slot_count), 512);
        check("full_mem0", int'(mem[0]), 8'h00);
        check("full_mem255", int'(mem[255]), 8'hFF);
        check("full_mem300", int'(mem[300]), 8'h2C);
        check("full_mem511", int'(mem[511]), 8'hFF);
        send_byte(8'hEE, 1'b1);
        check("byte513_no_write", wr_total - wr0, 512);
        check("byte513_no_done", fd_total - fd0, 1);

        snap();
        pulse_break();
        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b0);
        check("ferr_pulse", fe_total - fe0, 1);
        check("ferr_no_write", wr_total - wr0, 0);
        check("ferr_no_done", fd_total - fd0, 0);
        send_byte(8'h66, 1'b1);
        check("ferr_then_idle", wr_total - wr0, 0);

        snap();
        pulse_break();
        send_byte(8'hCC, 1'b1);
        send_byte(8'h01, 1'b1);
        check("sc_cc_value", int'(start_code), 8'hCC);
`ifdef DMX_RX_START_CODE_FILTER_EN
        check("sc_cc_no_write", wr_total - wr0, 0);
        pulse_break();
        check("sc_cc_no_done", fd_total - fd0, 0);
`else
        check("sc_cc_write", wr_total - wr0, 1);
        check("sc_cc_data", int'(mem[0]), 8'h01);
        pulse_break();
        check("sc_cc_done", fd_total - fd0, 1);
        check("sc_cc_count", int'(slot_count), 1);
`endif

        snap();
        pulse_break();
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h12, 1'b1);
        send_with_break(8'h13);
        check("coinc_writes", wr_total - wr0, 3);
        check("coinc_done", fd_total - fd0, 1);
        check("coinc_count", int'(slot_count), 3);
        check("coinc_mem2", int'(mem[2]), 8'h12);
        check("coinc_mem3_kept", int'(mem[3]), 8'h03);
        send_byte(8'h77, 1'b1);
        check("coinc_next_sc", int'(start_code), 8'h77);

        pulse_break();
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i), 1'b1);
        check("pre_rst_mem9", int'(mem[9]), 8'hA9);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_wr_en", int'(bus.wr_en), 0);
        check("mid_rst_slot_count", int'(slot_count), 0);
        check("mid_rst_frame_done", int'(frame_done), 0);
        check("mid_rst_frame_err", int'(frame_err), 0);
        check("mid_rst_start_code", int'(start_code), 0);
        rst = 1'b0;
        snap();
        send_byte(8'h44, 1'b1);
        send_byte(8'h45, 1'b1);
        check("post_rst_no_write", wr_total - wr0, 0);
        check("post_rst_no_done", fd_total - fd0, 0);
        check("post_rst_sc", int'(start_code), 0);
        pulse_break();
        send_byte(8'h00, 1'b1);
        send_byte(8'h99, 1'b1);
        check("post_rst_recover_wr", wr_total - wr0, 1);
        check("post_rst_recover_data", int'(mem[0]), 8'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
